// File: rtl/score_pkg.sv
// Shared widths and converter state encoding for the score sequencer slice.
package score_pkg;

  localparam int SCORE_W   = 9;
  localparam int BCD_W     = 12;
  localparam int SHIFT_CNT = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_t;

endpackage

// File: rtl/score_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter: one shift per cycle,
// result stays in the accumulator after DONE until the next LOAD.
module score_bcd_conv
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  localparam int CNT_W = $clog2(SHIFT_CNT + 1);

  conv_state_t        state_reg;
  logic [SCORE_W-1:0] sr_reg;
  logic [BCD_W-1:0]   acc_reg;
  logic [BCD_W-1:0]   acc_adj;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;

  // Per-nibble add-3 correction applied before every shift.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                  acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          sr_reg    <= value;
          acc_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= SHIFT;
        end
        SHIFT: begin
          acc_reg <= {acc_adj[BCD_W-2:0], sr_reg[SCORE_W-1]};
          sr_reg  <= {sr_reg[SCORE_W-2:0], 1'b0};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(SHIFT_CNT - 1)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= LOAD;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = acc_reg;

endmodule

// File: rtl/score_sequencer.sv
// Game score / high-score keeper with a BCD display path; a selected-value
// change requests a conversion, and requests arriving while busy merge into one.
module score_sequencer
  import score_pkg::*;
#(
  parameter int MAX_SCORE = 511
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  input  logic               game_over,
  input  logic               show_high,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_high,
  output logic [3:0]         bcd2,
  output logic [3:0]         bcd1,
  output logic [3:0]         bcd0,
  output logic               bcd_valid
);

  localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

  logic [SCORE_W-1:0] score_reg;
  logic [SCORE_W-1:0] high_reg;
  logic               new_high_reg;
  logic               go_prev_reg;
  logic [SCORE_W-1:0] sel_prev_reg;
  logic               show_prev_reg;
  logic               pending_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               bcd_valid_reg;

  logic [SCORE_W-1:0] sel_value;
  logic               req;
  logic               go_rise;
  logic               start;
  logic               accept;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  assign sel_value = show_high ? high_reg : score_reg;
  assign req       = (sel_value != sel_prev_reg) || (show_high != show_prev_reg);
  assign go_rise   = game_over && !go_prev_reg;
  assign start     = req || pending_reg;
  // The converter can take a new job from IDLE or straight out of DONE.
  assign accept    = !conv_busy || conv_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_reg    <= '0;
      high_reg     <= '0;
      new_high_reg <= 1'b0;
      go_prev_reg  <= 1'b0;
    end else begin
      go_prev_reg <= game_over;
      if (clear)
        score_reg <= '0;
      else if (inc && !game_over && (score_reg < MAX_VAL))
        score_reg <= score_reg + 1'b1;
      if (go_rise && (score_reg > high_reg))
        high_reg <= score_reg;
      if (clear)
        new_high_reg <= 1'b0;
      else if (go_rise && (score_reg > high_reg))
        new_high_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_prev_reg  <= '0;
      show_prev_reg <= 1'b0;
      pending_reg   <= 1'b0;
      bcd_reg       <= '0;
      bcd_valid_reg <= 1'b1;
    end else begin
      sel_prev_reg  <= sel_value;
      show_prev_reg <= show_high;
      if (accept && start)
        pending_reg <= 1'b0;
      else if (req)
        pending_reg <= 1'b1;
      // A result superseded by a newer request is never shown.
      if (conv_done && !start) begin
        bcd_reg       <= conv_bcd;
        bcd_valid_reg <= 1'b1;
      end else if (accept && start) begin
        bcd_valid_reg <= 1'b0;
      end
    end
  end

  score_bcd_conv u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (sel_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign score      = score_reg;
  assign high_score = high_reg;
  assign new_high   = new_high_reg;
  assign bcd2       = bcd_reg[11:8];
  assign bcd1       = bcd_reg[7:4];
  assign bcd0       = bcd_reg[3:0];
  assign bcd_valid  = bcd_valid_reg;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer: stimulus pushes expected display results,
// a monitor pops one per bcd_valid rising edge and checks digits and latency.
module tb_score_sequencer;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       inc;
  logic       game_over;
  logic       show_high;
  logic [8:0] score;
  logic [8:0] high_score;
  logic       new_high;
  logic [3:0] bcd2, bcd1, bcd0;
  logic       bcd_valid;

  typedef struct {
    logic [11:0] d;
    int          lat;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  score_sequencer #(.MAX_SCORE(511)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .inc        (inc),
    .game_over  (game_over),
    .show_high  (show_high),
    .score      (score),
    .high_score (high_score),
    .new_high   (new_high),
    .bcd2       (bcd2),
    .bcd1       (bcd1),
    .bcd0       (bcd0),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push(input int d2, input int d1, input int d0, input int lat);
    exp_t e;
    e.d   = {4'(d2), 4'(d1), 4'(d0)};
    e.lat = lat;
    q.push_back(e);
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inc = 1'b1;
    end
    @(negedge clk);
    inc = 1'b0;
  endtask

  task automatic do_clear(input logic with_inc);
    @(negedge clk);
    clear = 1'b1;
    inc   = with_inc;
    @(negedge clk);
    clear = 1'b0;
    inc   = 1'b0;
  endtask

  task automatic rise_go();
    @(negedge clk);
    game_over = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (!(bcd_valid && q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, pending=%0d valid=%0d required empty and valid", name, q.size(), bcd_valid);
    end
  endtask

  // Monitor: one popped expectation per rising bcd_valid.
  initial begin : monitor
    logic        prev_valid;
    logic [11:0] held;
    logic        moved;
    int          low_cnt;
    exp_t        e;
    prev_valid = 1'b1;
    held       = '0;
    moved      = 1'b0;
    low_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_valid = 1'b1;
      end else begin
        if (prev_valid && !bcd_valid) begin
          low_cnt = 0;
          held    = {bcd2, bcd1, bcd0};
          moved   = 1'b0;
        end
        if (!bcd_valid) begin
          low_cnt++;
          if ({bcd2, bcd1, bcd0} != held) moved = 1'b1;
        end
        if (!prev_valid && bcd_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %h expected no result", {bcd2, bcd1, bcd0});
          end else begin
            e = q.pop_front();
            total++;
            if ({bcd2, bcd1, bcd0} != e.d) begin
              bad++;
              $display("FAIL bcd_digits: got %h expected %h", {bcd2, bcd1, bcd0}, e.d);
            end else begin
              $display("ok   bcd_digits: %h", {bcd2, bcd1, bcd0});
            end
            chk("digits_held_while_busy", int'(moved), 0);
            if (e.lat != 0) chk("conv_latency", low_cnt, e.lat);
          end
        end
        prev_valid = bcd_valid;
      end
    end
  end

  initial begin : stim
    int n;
    clk = 1'b0; reset = 1'b0; clear = 1'b0; inc = 1'b0;
    game_over = 1'b0; show_high = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_score", score, 0);
    chk("rst_high", high_score, 0);
    chk("rst_new_high", new_high, 0);
    chk("rst_bcd", {bcd2, bcd1, bcd0}, 0);
    chk("rst_valid", bcd_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_conv_after_reset", bcd_valid, 1);

    // three increments from zero
    push(0, 0, 3, 0);
    pulse_inc(3);
    chk("score_3", score, 3);
    wait_idle("t_inc3");

    // clear, then five back-to-back increments merge into one result
    push(0, 0, 0, 11);
    do_clear(1'b0);
    wait_idle("t_clear0");
    push(0, 0, 5, 0);
    pulse_inc(5);
    chk("score_5", score, 5);
    wait_idle("t_inc5");

    // high score capture
    push(0, 0, 0, 11);
    do_clear(1'b0);
    wait_idle("t_clear1");
    push(1, 2, 7, 0);
    pulse_inc(127);
    wait_idle("t_inc127");
    chk("score_127", score, 127);
    rise_go();
    chk("high_127", high_score, 127);
    chk("new_high_set", new_high, 1);
    pulse_inc(1);
    chk("inc_ignored_game_over", score, 127);
    @(negedge clk);
    game_over = 1'b0;
    push(0, 0, 0, 11);
    do_clear(1'b1);
    chk("clear_beats_inc", score, 0);
    chk("clear_new_high", new_high, 0);
    chk("clear_keeps_high", high_score, 127);
    wait_idle("t_clear2");
    push(0, 5, 0, 0);
    pulse_inc(50);
    wait_idle("t_inc50");
    rise_go();
    chk("high_kept_127", high_score, 127);
    chk("new_high_low", new_high, 0);
    @(negedge clk);
    game_over = 1'b0;

    // display select toggling
    push(0, 0, 0, 11);
    do_clear(1'b0);
    wait_idle("t_clear3");
    push(0, 4, 2, 0);
    pulse_inc(42);
    wait_idle("t_inc42");
    push(1, 2, 7, 11);
    @(negedge clk);
    show_high = 1'b1;
    wait_idle("t_show_high");
    push(0, 4, 2, 11);
    @(negedge clk);
    show_high = 1'b0;
    wait_idle("t_show_score");

    // saturation
    push(0, 0, 0, 11);
    do_clear(1'b0);
    wait_idle("t_clear4");
    push(5, 1, 0, 0);
    pulse_inc(510);
    wait_idle("t_inc510");
    chk("score_510", score, 510);
    push(5, 1, 1, 0);
    pulse_inc(3);
    chk("score_sat_511", score, 511);
    wait_idle("t_sat");
    rise_go();
    chk("high_511", high_score, 511);
    chk("new_high_511", new_high, 1);
    @(negedge clk);
    game_over = 1'b0;

    // reset in the middle of a conversion
    do_clear(1'b0);
    n = 0;
    while (bcd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL conv_start_timeout: got valid=1 required valid=0");
    end
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_score", score, 0);
    chk("midrst_high", high_score, 0);
    chk("midrst_new_high", new_high, 0);
    chk("midrst_bcd", {bcd2, bcd1, bcd0}, 0);
    chk("midrst_valid", bcd_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(0, 0, 1, 11);
    pulse_inc(1);
    wait_idle("t_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
